// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy counter.
// Define MDU_MADD_EN to enable the MADD/MADDU accumulate operations (MDOp 6/7).
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MADD  = 3'd6,
        OP_MADDU = 3'd7
    } md_op_e;

    localparam logic [CNT_W-1:0] MULT_LAT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LAT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    md_op_e           op_q,   op_d;
    logic [31:0]      a_q,    a_d;
    logic [31:0]      b_q,    b_d;
    logic [31:0]      hi_q,   hi_d;
    logic [31:0]      lo_q,   lo_d;

    md_op_e op_in;
    assign op_in = md_op_e'(MDOp);

    // All arithmetic works only on the latched operands, never the live ports.
    logic [63:0] prod_s, prod_u;
    logic [31:0] b_safe, a_mag, b_mag, quo_mag, rem_mag, quo_s, rem_s, quo_u, rem_u;
    logic        b_zero;

    always_comb begin
        prod_s  = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
        b_zero  = (b_q == 32'd0);
        b_safe  = b_zero ? 32'd1 : b_q;
        // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow case.
        a_mag   = a_q[31] ? (32'd0 - a_q) : a_q;
        b_mag   = b_safe[31] ? (32'd0 - b_safe) : b_safe;
        quo_mag = a_mag / b_mag;
        rem_mag = a_mag % b_mag;
        quo_s   = (a_q[31] ^ b_safe[31]) ? (32'd0 - quo_mag) : quo_mag;
        rem_s   = a_q[31] ? (32'd0 - rem_mag) : rem_mag;
        quo_u   = a_q / b_safe;
        rem_u   = a_q % b_safe;
    end

`ifdef MDU_MADD_EN
    logic [63:0] acc_s, acc_u;
    always_comb begin
        acc_s = {hi_q, lo_q} + prod_s;
        acc_u = {hi_q, lo_q} + prod_u;
    end
`endif

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;

        if (busy_q) begin
            // A Start seen while busy (including the completion edge) is dropped.
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                busy_d = 1'b0;
                case (op_q)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_DIV: begin
                        if (!b_zero) begin
                            lo_d = quo_s;
                            hi_d = rem_s;
                        end
                    end
                    OP_DIVU: begin
                        if (!b_zero) begin
                            lo_d = quo_u;
                            hi_d = rem_u;
                        end
                    end
`ifdef MDU_MADD_EN
                    OP_MADD:  {hi_d, lo_d} = acc_s;
                    OP_MADDU: {hi_d, lo_d} = acc_u;
`endif
                    default: ;
                endcase
            end
        end else if (Start) begin
            case (op_in)
                OP_MULT, OP_MULTU,
`ifdef MDU_MADD_EN
                OP_MADD, OP_MADDU,
`endif
                OP_DIV, OP_DIVU: begin
                    busy_d = 1'b1;
                    op_d   = op_in;
                    a_d    = A;
                    b_d    = B;
                    cnt_d  = (op_in == OP_DIV || op_in == OP_DIVU) ? DIV_LAT : MULT_LAT;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            // NOTE: operand latches are reset too; they are plain flops, not a memory.
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= OP_MULT;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit; define MDU_MADD_EN to check the accumulate ops.
module tb_md_unit;

    logic        Clk;
    logic        Rst;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int errors = 0;
    int checks = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .MDOp  (MDOp),
        .A     (A),
        .B     (B),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle Start pulse, then count the cycles Busy stays high (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n_exp, input string tag);
        int n;
        @(negedge Clk);
        Start = 1'b1; MDOp = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0;
        n = 0;
        while (Busy && n < 50) begin
            n++;
            @(negedge Clk);
        end
        check({tag, "_busy_cycles"}, 64'(n), 64'(n_exp));
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] a);
        @(negedge Clk);
        Start = 1'b1; MDOp = op; A = a;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    initial begin
        int n;
        Rst = 1'b1; Start = 1'b0; MDOp = 3'd0; A = '0; B = '0;
        #2;
        check("reset_busy", 64'(Busy), 64'd0);
        check("reset_hi",   64'(HI),   64'd0);
        check("reset_lo",   64'(LO),   64'd0);
        @(negedge Clk);
        Rst = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 5, "mult");
        check("mult_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);
        check("mult_lo", 64'(LO), 64'h0000_0000_FFFF_FFFA);

        run_op(3'd3, 32'd100, 32'd7, 10, "divu");
        check("divu_lo", 64'(LO), 64'd14);
        check("divu_hi", 64'(HI), 64'd2);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 10, "div");
        check("div_lo", 64'(LO), 64'h0000_0000_FFFF_FFFD);
        check("div_hi", 64'(HI), 64'h0000_0000_FFFF_FFFF);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, "div_ovf");
        check("div_ovf_lo", 64'(LO), 64'h0000_0000_8000_0000);
        check("div_ovf_hi", 64'(HI), 64'd0);

        move_to(3'd4, 32'h1234);
        move_to(3'd5, 32'h5678);
        run_op(3'd2, 32'd5, 32'd0, 10, "div0");
        check("div0_hi", 64'(HI), 64'h1234);
        check("div0_lo", 64'(LO), 64'h5678);

        move_to(3'd4, 32'hAA);
        check("mthi_busy", 64'(Busy), 64'd0);
        check("mthi_hi",   64'(HI),   64'hAA);

        // MULTU with operand changes, a Start while busy and a Start on the completion edge.
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            if (Busy) n++;
            case (k)
                1: begin Start = 1'b0; A = '0; B = '0; end
                2: begin Start = 1'b1; MDOp = 3'd3; A = 32'd9; B = 32'd3; end
                3: Start = 1'b0;
                5: Start = 1'b1;
                6: Start = 1'b0;
                default: ;
            endcase
        end
        check("multu_busy_cycles", 64'(n), 64'd5);
        check("multu_hi", 64'(HI), 64'h0000_0000_FFFF_FFFE);
        check("multu_lo", 64'(LO), 64'h0000_0000_0000_0001);
        check("multu_idle", 64'(Busy), 64'd0);

        // Repeat run, aborted by an asynchronous reset pulse in its third busy cycle.
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd1; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        #1 Rst = 1'b1;
        #1;
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_hi",   64'(HI),   64'd0);
        check("abort_lo",   64'(LO),   64'd0);
        #1 Rst = 1'b0;
        repeat (12) @(negedge Clk);
        check("abort_late_busy", 64'(Busy), 64'd0);
        check("abort_late_hi",   64'(HI),   64'd0);
        check("abort_late_lo",   64'(LO),   64'd0);

`ifdef MDU_MADD_EN
        move_to(3'd4, 32'h0);
        move_to(3'd5, 32'hFFFF_FFFF);
        run_op(3'd7, 32'd1, 32'd1, 5, "maddu");
        check("maddu_hi", 64'(HI), 64'd1);
        check("maddu_lo", 64'(LO), 64'd0);
        run_op(3'd6, 32'hFFFF_FFFF, 32'd1, 5, "madd");
        check("madd_hi", 64'(HI), 64'd0);
        check("madd_lo", 64'(LO), 64'h0000_0000_FFFF_FFFF);
`else
        move_to(3'd4, 32'h11);
        move_to(3'd5, 32'h22);
        @(negedge Clk);
        Start = 1'b1; MDOp = 3'd6; A = 32'd3; B = 32'd3;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge Clk);
            Start = 1'b0;
            if (Busy) n++;
        end
        check("madd_off_busy", 64'(n), 64'd0);
        check("madd_off_hi", 64'(HI), 64'h11);
        check("madd_off_lo", 64'(LO), 64'h22);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
